// File: rtl/apb_pad_ctrl_pkg.sv
// Shared types and register-map constants for the APB pad-frame controller.
package apb_pad_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_APPLY  = 2'd2
   } commit_state_e;

   localparam logic [3:0] REG_GLOBAL = 4'd0;
   localparam logic [3:0] REG_SHADOW = 4'd1;
   localparam logic [3:0] REG_ACTIVE = 4'd2;

   localparam logic [5:0] IDX_CTRL = 6'd0;
   localparam logic [5:0] IDX_INFO = 6'd1;

   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_LOCK_BIT   = 1;
   localparam int CTRL_BUSY_BIT   = 8;

   localparam logic [7:0] VERSION = 8'h02;

endpackage

// File: rtl/apb_pad_commit_fsm.sv
// Commit sequencer: waits SETTLE_CYCLES after a commit request, then issues a
// single apply strobe and a done pulse in the cycle the new values appear.
module apb_pad_commit_fsm
   import apb_pad_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic start_i,
   output logic busy_o,
   output logic commit_done_o,
   output logic apply_o
);

   commit_state_e state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (SETTLE_CYCLES == 0) begin
                  state_d = ST_APPLY;
               end else begin
                  state_d = ST_SETTLE;
                  cnt_d   = 8'(SETTLE_CYCLES);
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q <= 8'd1) state_d = ST_APPLY;
            else               cnt_d   = cnt_q - 8'd1;
         end
         ST_APPLY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      // Active registers load at the end of APPLY, so done lines up with them.
      done_d = (state_q == ST_APPLY);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o        = busy_q;
   assign commit_done_o = done_q;
   assign apply_o       = (state_q == ST_APPLY);

endmodule

// File: rtl/apb_pad_ctrl.sv
// APB slave holding shadow and active pad mux/config registers; a COMMIT copies
// every shadow entry to the pad frame at once after a settle delay.
module apb_pad_ctrl
   import apb_pad_ctrl_pkg::*;
#(
   parameter int               APB_ADDR_WIDTH = 12,
   parameter int               N_PADS         = 32,
   parameter int               MUX_W          = 2,
   parameter int               CFG_W          = 6,
   parameter int               SETTLE_CYCLES  = 4,
   parameter logic [CFG_W-1:0] CFG_RST_VAL    = '0
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [31:0]                   PWDATA,
   input  logic                          PWRITE,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   output logic [31:0]                   PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic [N_PADS-1:0][MUX_W-1:0]  pad_mux_o,
   output logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_o,
   output logic                          busy_o,
   output logic                          commit_done_o
);

   localparam int IDX_W = (N_PADS > 1) ? $clog2(N_PADS) : 1;

   logic [3:0]       region;
   logic [5:0]       idx;
   logic [IDX_W-1:0] pad;
   logic             access, rd_acc, wr_acc, idx_ok;
   logic             is_ctrl, is_info, is_shadow, is_active;
   logic             err, stall, wr_en, start, apply, busy;
   logic [31:0]      rdata;
   logic             lock_q, lock_d;
   logic             unused_bits;

   logic [N_PADS-1:0][MUX_W-1:0] sh_mux_q, sh_mux_d, act_mux_q, act_mux_d;
   logic [N_PADS-1:0][CFG_W-1:0] sh_cfg_q, sh_cfg_d, act_cfg_q, act_cfg_d;

   assign region    = PADDR[11:8];
   assign idx       = PADDR[7:2];
   assign pad       = idx[IDX_W-1:0];
   assign idx_ok    = ({1'b0, idx} < 7'(N_PADS));
   assign access    = PSEL && PENABLE;
   assign rd_acc    = access && !PWRITE;
   assign wr_acc    = access && PWRITE;
   assign is_ctrl   = (region == REG_GLOBAL) && (idx == IDX_CTRL);
   assign is_info   = (region == REG_GLOBAL) && (idx == IDX_INFO);
   assign is_shadow = (region == REG_SHADOW) && idx_ok;
   assign is_active = (region == REG_ACTIVE) && idx_ok;

   always_comb begin
      err = 1'b1;
      if (is_ctrl)        err = PWRITE && PWDATA[CTRL_COMMIT_BIT] && lock_q;
      else if (is_info)   err = PWRITE;
      else if (is_shadow) err = PWRITE && lock_q;
      else if (is_active) err = PWRITE;
   end

   always_comb begin
      rdata = '0;
      if (is_ctrl) begin
         rdata[CTRL_LOCK_BIT] = lock_q;
         rdata[CTRL_BUSY_BIT] = busy;
      end else if (is_info) begin
         rdata = {8'(N_PADS), 4'(MUX_W), 4'(CFG_W), 8'(SETTLE_CYCLES), VERSION};
      end else if (is_shadow) begin
         rdata[MUX_W-1:0]  = sh_mux_q[pad];
         rdata[16 +: CFG_W] = sh_cfg_q[pad];
      end else if (is_active) begin
         rdata[MUX_W-1:0]  = act_mux_q[pad];
         rdata[16 +: CFG_W] = act_cfg_q[pad];
      end
   end

   // Writes that could disturb a running commit wait for IDLE; reads never stall.
   assign stall   = wr_acc && busy && (is_ctrl || is_shadow);
   assign wr_en   = wr_acc && !stall && !err;
   assign start   = wr_en && is_ctrl && PWDATA[CTRL_COMMIT_BIT];
   assign PREADY  = !stall;
   assign PSLVERR = access && !stall && err;
   assign PRDATA  = (rd_acc && !err) ? rdata : 32'd0;

   always_comb begin
      lock_d    = lock_q | (wr_en && is_ctrl && PWDATA[CTRL_LOCK_BIT]);
      sh_mux_d  = sh_mux_q;
      sh_cfg_d  = sh_cfg_q;
      act_mux_d = act_mux_q;
      act_cfg_d = act_cfg_q;
      if (wr_en && is_shadow) begin
         sh_mux_d[pad] = PWDATA[MUX_W-1:0];
         sh_cfg_d[pad] = PWDATA[16 +: CFG_W];
      end
      if (apply) begin
         act_mux_d = sh_mux_q;
         act_cfg_d = sh_cfg_q;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         lock_q    <= 1'b0;
         sh_mux_q  <= '0;
         act_mux_q <= '0;
         sh_cfg_q  <= {N_PADS{CFG_RST_VAL}};
         act_cfg_q <= {N_PADS{CFG_RST_VAL}};
      end else begin
         lock_q    <= lock_d;
         sh_mux_q  <= sh_mux_d;
         act_mux_q <= act_mux_d;
         sh_cfg_q  <= sh_cfg_d;
         act_cfg_q <= act_cfg_d;
      end
   end

   apb_pad_commit_fsm #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_commit_fsm (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .start_i       (start),
      .busy_o        (busy),
      .commit_done_o (commit_done_o),
      .apply_o       (apply)
   );

   assign busy_o      = busy;
   assign pad_mux_o   = act_mux_q;
   assign pad_cfg_o   = act_cfg_q;
   assign unused_bits = ^{PADDR, PWDATA};

endmodule

// File: tb/tb_apb_pad_ctrl.sv
// Bench for apb_pad_ctrl: a 32-pad/settle-4 instance and a 4-pad/settle-0
// instance on a shared APB bus, checked against a register-level model.
module tb_apb_pad_ctrl;

   localparam logic [5:0] RST_CFG = 6'h2A;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [11:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic        PWRITE = 1'b0, PENABLE = 1'b0, psel = 1'b0, use0 = 1'b0;
   logic        psel1, psel0;

   logic [31:0]      prdata1, prdata0;
   logic             pready1, pready0, pslverr1, pslverr0;
   logic [31:0][1:0] mux1;
   logic [31:0][5:0] cfg1;
   logic [3:0][1:0]  mux0;
   logic [3:0][5:0]  cfg0;
   logic             busy1, busy0, done1, done0;

   logic [31:0]  prdata_s;
   logic         pready_s, pslverr_s, busy_s, done_s;
   logic [63:0]  mux_s;
   logic [191:0] cfg_s;

   always #5 HCLK = ~HCLK;

   assign psel1     = psel & ~use0;
   assign psel0     = psel & use0;
   assign prdata_s  = use0 ? prdata0 : prdata1;
   assign pready_s  = use0 ? pready0 : pready1;
   assign pslverr_s = use0 ? pslverr0 : pslverr1;
   assign busy_s    = use0 ? busy0 : busy1;
   assign done_s    = use0 ? done0 : done1;
   assign mux_s     = use0 ? {56'b0, mux0} : mux1;
   assign cfg_s     = use0 ? {168'b0, cfg0} : cfg1;

   apb_pad_ctrl #(.APB_ADDR_WIDTH(12), .N_PADS(32), .MUX_W(2), .CFG_W(6),
                  .SETTLE_CYCLES(4), .CFG_RST_VAL(RST_CFG)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(psel1), .PENABLE(PENABLE), .PRDATA(prdata1),
      .PREADY(pready1), .PSLVERR(pslverr1), .pad_mux_o(mux1), .pad_cfg_o(cfg1),
      .busy_o(busy1), .commit_done_o(done1));

   apb_pad_ctrl #(.APB_ADDR_WIDTH(12), .N_PADS(4), .MUX_W(2), .CFG_W(6),
                  .SETTLE_CYCLES(0), .CFG_RST_VAL(RST_CFG)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(psel0), .PENABLE(PENABLE), .PRDATA(prdata0),
      .PREADY(pready0), .PSLVERR(pslverr0), .pad_mux_o(mux0), .pad_cfg_o(cfg0),
      .busy_o(busy0), .commit_done_o(done0));

   // Reference model: plain arrays of register contents.
   int         npads = 32;
   int         settle = 4;
   logic [1:0] m_sh_mux[32], m_act_mux[32];
   logic [5:0] m_sh_cfg[32], m_act_cfg[32];
   logic       m_lock;
   int         tests = 0, fails = 0;

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_sh_mux[i] = 2'd0;  m_act_mux[i] = 2'd0;
         m_sh_cfg[i] = RST_CFG; m_act_cfg[i] = RST_CFG;
      end
      m_lock = 1'b0;
   endtask

   function automatic logic [63:0] exp_mux();
      logic [63:0] v = '0;
      for (int i = 0; i < npads; i++) v[2*i +: 2] = m_act_mux[i];
      return v;
   endfunction

   function automatic logic [191:0] exp_cfg();
      logic [191:0] v = '0;
      for (int i = 0; i < npads; i++) v[6*i +: 6] = m_act_cfg[i];
      return v;
   endfunction

   function automatic logic [31:0] sh_word(input int i);
      return {10'b0, m_sh_cfg[i], 14'b0, m_sh_mux[i]};
   endfunction

   function automatic logic [31:0] act_word(input int i);
      return {10'b0, m_act_cfg[i], 14'b0, m_act_mux[i]};
   endfunction

   function automatic logic [11:0] addr(input logic [3:0] r, input logic [5:0] i);
      return {r, i, 2'b00};
   endfunction

   task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err, output int waits);
      waits = 0;
      @(posedge HCLK); #1;
      psel = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      @(negedge HCLK);
      while (!pready_s && waits < 200) begin
         waits++;
         @(negedge HCLK);
      end
      check("apb_ready", pready_s, 1'b1);
      rd  = prdata_s;
      err = pslverr_s;
      @(posedge HCLK); #1;
      psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a,
                         input logic [31:0] exp, input logic exp_err);
      logic [31:0] rd; logic err; int w;
      apb_xfer(1'b0, a, 32'd0, rd, err, w);
      check({tag, "_data"}, rd, exp);
      check({tag, "_err"}, err, exp_err);
   endtask

   task automatic wr_shadow(input int i, input logic [31:0] d);
      logic [31:0] rd; logic err; int w; logic exp_err;
      exp_err = m_lock || (i >= npads);
      apb_xfer(1'b1, addr(4'd1, 6'(i)), d, rd, err, w);
      check($sformatf("wr_shadow%0d_err", i), err, exp_err);
      if (!exp_err) begin
         m_sh_mux[i] = d[1:0];
         m_sh_cfg[i] = d[21:16];
      end
   endtask

   // Commit with cycle-exact checks: old values through T+S+1, new at T+S+2.
   task automatic do_commit(input logic [31:0] ctrl, input string tag);
      logic [63:0] om, nm; logic [191:0] oc, nc; logic [31:0] rd; logic err; int w;
      om = exp_mux(); oc = exp_cfg();
      apb_xfer(1'b1, addr(4'd0, 6'd0), ctrl, rd, err, w);
      check({tag, "_err"}, err, 1'b0);
      for (int i = 0; i < 32; i++) begin
         m_act_mux[i] = m_sh_mux[i];
         m_act_cfg[i] = m_sh_cfg[i];
      end
      if (ctrl[1]) m_lock = 1'b1;
      nm = exp_mux(); nc = exp_cfg();
      for (int k = 1; k <= settle + 2; k++) begin
         @(negedge HCLK);
         check($sformatf("%s_busy_c%0d", tag, k), busy_s, (k <= settle + 1));
         check($sformatf("%s_done_c%0d", tag, k), done_s, (k == settle + 2));
         check($sformatf("%s_mux_c%0d", tag, k), mux_s, (k == settle + 2) ? nm : om);
         check($sformatf("%s_cfg_c%0d", tag, k), cfg_s, (k == settle + 2) ? nc : oc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd; logic err; int w; int p;
      model_reset();
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_pready", pready_s, 1'b1);
      check("rst_pslverr", pslverr_s, 1'b0);
      check("rst_prdata", prdata_s, 32'd0);
      check("rst_busy", busy_s, 1'b0);
      check("rst_done", done_s, 1'b0);
      check("rst_mux", mux_s, exp_mux());
      check("rst_cfg", cfg_s, exp_cfg());
      HRESETn = 1'b1;

      rd_chk("info", addr(4'd0, 6'd1), 32'h2026_0402, 1'b0);
      rd_chk("ctrl_rst", addr(4'd0, 6'd0), 32'd0, 1'b0);
      rd_chk("shadow0_rst", addr(4'd1, 6'd0), 32'h002A_0000, 1'b0);
      rd_chk("active0_rst", addr(4'd2, 6'd0), 32'h002A_0000, 1'b0);

      wr_shadow(3, 32'h0015_0002);
      rd_chk("active3_pre", addr(4'd2, 6'd3), act_word(3), 1'b0);
      do_commit(32'h1, "commit_s3");
      rd_chk("active3_post", addr(4'd2, 6'd3), 32'h0015_0002, 1'b0);

      for (int r = 0; r < 5; r++) begin
         for (int n = 0; n < int'($urandom_range(1, 5)); n++)
            wr_shadow(int'($urandom_range(0, 31)), $urandom);
         p = int'($urandom_range(0, 31));
         rd_chk($sformatf("rand%0d_shadow%0d", r, p), addr(4'd1, 6'(p)), sh_word(p), 1'b0);
         p = int'($urandom_range(0, 31));
         rd_chk($sformatf("rand%0d_active%0d", r, p), addr(4'd2, 6'(p)), act_word(p), 1'b0);
         do_commit(32'h1, $sformatf("commit_r%0d", r));
      end

      // SHADOW write issued right behind a COMMIT stalls until the FSM is idle.
      apb_xfer(1'b1, addr(4'd0, 6'd0), 32'h1, rd, err, w);
      check("stall_commit_err", err, 1'b0);
      for (int i = 0; i < 32; i++) begin
         m_act_mux[i] = m_sh_mux[i];
         m_act_cfg[i] = m_sh_cfg[i];
      end
      apb_xfer(1'b1, addr(4'd1, 6'd7), 32'h0033_0003, rd, err, w);
      check("stall_waits", w, 3);
      check("stall_wr_err", err, 1'b0);
      m_sh_mux[7] = 2'd3; m_sh_cfg[7] = 6'h33;
      @(negedge HCLK);
      check("stall_busy", busy_s, 1'b0);
      check("stall_mux", mux_s, exp_mux());
      check("stall_cfg", cfg_s, exp_cfg());
      rd_chk("stall_active7_old", addr(4'd2, 6'd7), act_word(7), 1'b0);
      rd_chk("stall_shadow7", addr(4'd1, 6'd7), 32'h0033_0003, 1'b0);
      do_commit(32'h1, "commit_s7");
      rd_chk("active7_new", addr(4'd2, 6'd7), 32'h0033_0003, 1'b0);

      rd_chk("err_idx40_rd", addr(4'd1, 6'd40), 32'd0, 1'b1);
      wr_shadow(40, 32'h0001_0001);
      apb_xfer(1'b1, addr(4'd0, 6'd1), 32'hFFFF_FFFF, rd, err, w);
      check("err_info_wr", err, 1'b1);
      rd_chk("err_region3_rd", addr(4'd3, 6'd0), 32'd0, 1'b1);
      apb_xfer(1'b1, addr(4'd2, 6'd0), 32'h0003_0003, rd, err, w);
      check("err_active_wr", err, 1'b1);
      rd_chk("err_idx2_rd", addr(4'd0, 6'd2), 32'd0, 1'b1);
      rd_chk("err_nochange_info", addr(4'd0, 6'd1), 32'h2026_0402, 1'b0);
      rd_chk("err_nochange_active0", addr(4'd2, 6'd0), act_word(0), 1'b0);

      // Reset pulse while the FSM is in SETTLE.
      wr_shadow(5, 32'h0011_0001);
      apb_xfer(1'b1, addr(4'd0, 6'd0), 32'h1, rd, err, w);
      check("midrst_commit_err", err, 1'b0);
      repeat (2) @(posedge HCLK);
      #2 HRESETn = 1'b0;
      model_reset();
      #2;
      check("midrst_busy_low", busy_s, 1'b0);
      check("midrst_mux_low", mux_s, exp_mux());
      check("midrst_cfg_low", cfg_s, exp_cfg());
      @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (8) @(negedge HCLK);
      check("midrst_busy_after", busy_s, 1'b0);
      check("midrst_done_after", done_s, 1'b0);
      check("midrst_mux_after", mux_s, exp_mux());
      check("midrst_cfg_after", cfg_s, exp_cfg());
      rd_chk("midrst_shadow5", addr(4'd1, 6'd5), 32'h002A_0000, 1'b0);

      // COMMIT and LOCK in one write: commits, then locks.
      wr_shadow(2, 32'h0007_0001);
      do_commit(32'h3, "commit_lock");
      rd_chk("ctrl_locked", addr(4'd0, 6'd0), 32'h2, 1'b0);
      wr_shadow(1, 32'h003F_0003);
      apb_xfer(1'b1, addr(4'd0, 6'd0), 32'h1, rd, err, w);
      check("locked_commit_err", err, 1'b1);
      apb_xfer(1'b1, addr(4'd0, 6'd0), 32'h2, rd, err, w);
      check("locked_relock_err", err, 1'b0);
      repeat (3) @(negedge HCLK);
      check("locked_busy", busy_s, 1'b0);
      check("locked_mux", mux_s, exp_mux());
      rd_chk("locked_shadow1", addr(4'd1, 6'd1), sh_word(1), 1'b0);

      // Zero settle delay, four pads.
      use0 = 1'b1;
      npads = 4;
      settle = 0;
      model_reset();
      rd_chk("s0_info", addr(4'd0, 6'd1), 32'h0426_0002, 1'b0);
      wr_shadow(1, 32'h0009_0003);
      do_commit(32'h1, "commit_s0");
      rd_chk("s0_active1", addr(4'd2, 6'd1), 32'h0009_0003, 1'b0);
      rd_chk("s0_idx4_rd", addr(4'd1, 6'd4), 32'd0, 1'b1);
      wr_shadow(4, 32'h0001_0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_pad_ctrl.md
# apb_pad_ctrl

Parametrised APB slave that holds per-pad function-select and electrical configuration for the pad frame, with N_PADS pads of MUX_W select bits and CFG_W config bits each. Software writes a shadow copy; a COMMIT command applies all shadow values to the active outputs atomically, after a programmable settle delay. A sticky LOCK bit freezes the configuration until reset. Sits on the peripheral APB bus next to the GPIO block and drives the pad frame directly.

## Interface
- APB_ADDR_WIDTH, 12: APB address width; only PADDR[11:2] is decoded.
- N_PADS, 32: number of pads, 1..64.
- MUX_W, 2: function-select bits per pad, 1..8.
- CFG_W, 6: config bits per pad, 1..16.
- SETTLE_CYCLES, 4: wait cycles between COMMIT and apply, 0..255.
- CFG_RST_VAL, '0: reset value of every pad's config field (CFG_W bits).
- HCLK  in  1  clock.
- HRESETn  in  1  reset: asynchronous, active-low.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1 each  APB control.
- PRDATA  out  32  read data; 0 when no read access is in progress.
- PREADY  out  1  0 inserts wait states.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- pad_mux_o  out  [N_PADS-1:0][MUX_W-1:0]  active function select.
- pad_cfg_o  out  [N_PADS-1:0][CFG_W-1:0]  active config.
- busy_o  out  1  commit in progress.
- commit_done_o  out  1  one-cycle pulse when new active values first appear.

## Operation
- Decode on PADDR[11:8] (region) and PADDR[7:2] (index i).
- Region 0, index 0, CTRL: bit0 COMMIT (write 1 starts a commit; reads 0), bit1 LOCK (write 1 sets it; only reset clears it), bit8 BUSY (read-only).
- Region 0, index 1, INFO (RO): {8'(N_PADS), 4'(MUX_W), 4'(CFG_W), 8'(SETTLE_CYCLES), 8'h02 version}.
- Region 1, SHADOW[i] (RW): bits [MUX_W-1:0] = mux, bits [16+CFG_W-1:16] = cfg; all other bits read 0.
- Region 2, ACTIVE[i] (RO): same layout, returns the active registers.
- PSLVERR=1, with no state change, for any of:
  - unmapped region or index;
  - i >= N_PADS;
  - a write to INFO or ACTIVE;
  - a write to SHADOW while LOCK=1;
  - a write of COMMIT=1 while LOCK=1.
- A CTRL write with both COMMIT=1 and LOCK=1 sets LOCK and also performs the commit; the commit check uses the LOCK value from before the write.
- FSM states: IDLE, SETTLE, APPLY.
  - IDLE -> SETTLE on a COMMIT write and loads the counter with SETTLE_CYCLES.
  - When SETTLE_CYCLES=0, IDLE goes directly to APPLY.
  - SETTLE decrements the counter and goes to APPLY once it reaches 1.
  - APPLY copies all shadow registers to the active registers, then returns to IDLE.
- Outputs are held at their old active values until the copy.
- Reset values: shadow and active mux = 0, cfg = CFG_RST_VAL, LOCK = 0, FSM = IDLE, busy_o = 0, commit_done_o = 0, PREADY = 1, PSLVERR = 0, PRDATA = 0.

## Timing
- Writes take effect on the HCLK edge that ends the access phase with PREADY=1. PRDATA is combinational in the access phase.
- Reads never stall: PREADY=1 for all reads, including reads during a commit.
- Writes to CTRL or SHADOW while busy_o=1 are held with PREADY=0 until the FSM reaches IDLE, then complete normally. A second COMMIT therefore never overlaps the first.
- Commit latency, with the COMMIT write accepted at edge T and S = SETTLE_CYCLES:
  - busy_o is 1 from cycle T+1 through T+S+1 (APPLY is cycle T+S+1).
  - New pad_mux_o/pad_cfg_o values and commit_done_o=1 appear in cycle T+S+2.
  - busy_o is 0 in cycle T+S+2.
- A SHADOW write accepted in the same cycle as APPLY is impossible, because that write is stalled.
- HRESETn asserted mid-commit: all state returns to reset values immediately; no partial apply is visible.

## Structure
- Package apb_pad_ctrl_pkg holds:
  - the FSM state enum;
  - region constants (REG_GLOBAL=0, REG_SHADOW=1, REG_ACTIVE=2);
  - CTRL/INFO index constants and CTRL bit positions;
  - VERSION = 8'h02.
- One sub-module, apb_pad_commit_fsm: FSM, settle counter, busy_o, commit_done_o and an apply strobe. The register array and APB decode stay in the top.

## Test plan
- Reset, then read all regions: SHADOW/ACTIVE[0] = cfg CFG_RST_VAL<<16; INFO = {8'd32, 4'd2, 4'd6, 8'd4, 8'h02}; pad outputs 0/CFG_RST_VAL.
- Write SHADOW[3] = 0x0015_0002, then COMMIT: pad_mux_o[3] is unchanged for 5 cycles, then 2 with pad_cfg_o[3] = 0x15 in cycle T+6, coinciding with commit_done_o; busy_o is high T+1..T+5.
- Write SHADOW[7] during busy: PREADY is low until the FSM reaches IDLE, then the write completes; ACTIVE[7] keeps its old value until the next commit.
- Set LOCK, then write SHADOW[1] and COMMIT: both give PSLVERR=1, with no change and busy_o staying 0.
- Access index 40 with N_PADS=32, write to INFO, and access region 3: PSLVERR=1, read returns 0.
- With SETTLE_CYCLES=0, apply lands at T+2. Pulse HRESETn during SETTLE: outputs stay at reset values and busy_o=0.
